gol_grid_engine: RTL

//  Datapath responder to the Game-of-Life FSM controller.

---
 rtl/gol_pkg.sv | 19 +
 rtl/gol_cell_rule.sv | 48 ++++
 rtl/gol_grid_engine.sv | 83 ++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared constants, index type and row/column helpers for the Game-of-Life grid engine.
package gol_pkg;

  localparam int GRID_ROWS  = 4;
  localparam int GRID_COLS  = 4;
  localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;
  localparam int CNT_W      = 9;

  typedef logic [CNT_W-1:0] cell_idx_t;

  function automatic int idx_to_row(input int idx, input int cols);
    return idx / cols;
  endfunction

  function automatic int idx_to_col(input int idx, input int cols);
    return idx % cols;
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational Life rule for one cell: counts the 8 neighbours of idx in grid
// and produces that cell's next state.
module gol_cell_rule
  import gol_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS,
  parameter int COLS  = GRID_COLS,
  parameter int CNT_W = 9,
  parameter int WRAP  = 0
) (
  input  logic [ROWS*COLS-1:0] grid,
  input  logic [CNT_W-1:0]     idx,
  output logic                 next_bit
);

  localparam int CELLS = ROWS * COLS;

  int         row_s;
  int         col_s;
  int         nr_s;
  int         nc_s;
  logic [3:0] n_s;
  logic       self_s;

  // Neighbour count and rule; cells are picked with a one-hot mask so no index is ever out of range.
  always_comb begin
    n_s    = 4'd0;
    row_s  = idx_to_row(int'(idx), COLS);
    col_s  = idx_to_col(int'(idx), COLS);
    nr_s   = 0;
    nc_s   = 0;
    self_s = (grid & (CELLS'(1) << int'(idx))) != '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr_s = (WRAP != 0) ? (row_s + dr + ROWS) % ROWS : row_s + dr;
        nc_s = (WRAP != 0) ? (col_s + dc + COLS) % COLS : col_s + dc;
        if ((dr != 0 || dc != 0) && nr_s >= 0 && nr_s < ROWS && nc_s >= 0 && nc_s < COLS &&
            (grid & (CELLS'(1) << (nr_s * COLS + nc_s))) != '0) begin
          n_s = n_s + 4'd1;
        end else begin
          n_s = n_s;
        end
      end
    end
    next_bit = (n_s == 4'd3) || (self_s && (n_s == 4'd2));
  end

endmodule

// File: rtl/gol_grid_engine.sv
// Game-of-Life grid datapath: seed load, per-cell evaluation sweep, generation commit
// and extinction/stability status for the controller.
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS,
  parameter int COLS  = GRID_COLS,
  parameter int CNT_W = 9,
  parameter int GEN_W = 9,
  parameter int WRAP  = 0
) (
  input  logic                 clka,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 loadData,
  input  logic                 readData,
  input  logic                 writeData,
  input  logic                 writeout,
  input  logic [CNT_W-1:0]     count,
  input  logic                 data_in,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 loseSig,
  output logic                 stable
);

  localparam int CELLS = ROWS * COLS;

  logic [CELLS-1:0] grid_r;
  logic [CELLS-1:0] next_grid_r;
  logic [GEN_W-1:0] gen_r;
  logic             lose_r;
  logic             stable_r;
  logic             in_range_s;
  logic [CELLS-1:0] sel_s;
  logic             next_bit_s;

  assign in_range_s = count < CNT_W'(CELLS);
  assign sel_s      = CELLS'(1) << count;

  gol_cell_rule #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CNT_W (CNT_W),
    .WRAP  (WRAP)
  ) u_rule (
    .grid     (grid_r),
    .idx      (count),
    .next_bit (next_bit_s)
  );

  // Command decode in fixed priority; only the highest-priority command acts each edge.
  always_ff @(posedge clka) begin
    if (reset || restart) begin
      grid_r      <= '0;
      next_grid_r <= '0;
      gen_r       <= '0;
      lose_r      <= 1'b0;
      stable_r    <= 1'b0;
    end else if (writeout) begin
      grid_r   <= next_grid_r;
      stable_r <= (next_grid_r == grid_r);
      lose_r   <= lose_r | (next_grid_r == '0);
      if (gen_r != {GEN_W{1'b1}}) begin
        gen_r <= gen_r + GEN_W'(1);
      end
    end else if (loadData && writeData) begin
      if (in_range_s) begin
        grid_r <= data_in ? (grid_r | sel_s) : (grid_r & ~sel_s);
      end
    end else if (readData && writeData) begin
      if (in_range_s) begin
        next_grid_r <= next_bit_s ? (next_grid_r | sel_s) : (next_grid_r & ~sel_s);
      end
    end
  end

  assign grid_out  = grid_r;
  assign gen_count = gen_r;
  assign loseSig   = lose_r;
  assign stable    = stable_r;

endmodule
